// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, digit count default and the number-entry FSM encoding.
// Used by the scanner, the number-entry block and the display stage.
package keypad_pkg;

  localparam int unsigned NDIG_DEFAULT = 4;
  localparam int unsigned BIN_W        = 14;

  localparam logic [3:0] KEY_STAR_CODE = 4'd14;
  localparam logic [3:0] KEY_HASH_CODE = 4'd15;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_CONV  = 2'd1,
    ST_DONE  = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_to_bin.sv
// Serial BCD-to-binary converter: one nibble per cycle, most significant first, acc = acc*10 + nibble.
// done_o is high during the cycle in which the final nibble is being added.
module bcd_serial_to_bin
  import keypad_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [4*NDIG-1:0] bcd_i,
  output logic              done_o,
  output logic [BIN_W-1:0]  result_o
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic             active_q, active_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [3:0]       nibble;

  assign nibble   = bcd_i[4*idx_q +: 4];
  assign done_o   = active_q && (idx_q == '0);
  assign result_o = acc_q;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = IDX_W'(NDIG - 1);
      acc_d    = '0;
    end else if (active_q) begin
      // x*10 as (x<<3)+(x<<1); 9999 fits in BIN_W bits so nothing wraps
      acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(nibble);
      idx_d = idx_q - 1'b1;
      if (idx_q == '0) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/keypad_number_entry.sv
// Collects decimal key presses into a BCD entry register; '*' clears, '#' converts the entry
// to binary and pulses num_valid. Keys arriving during conversion are dropped and flagged.
module keypad_number_entry
  import keypad_pkg::*;
#(
  parameter int unsigned NDIG     = NDIG_DEFAULT,
  parameter logic [3:0]  KEY_STAR = KEY_STAR_CODE,
  parameter logic [3:0]  KEY_HASH = KEY_HASH_CODE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid,
  input  logic [3:0]                  key_code,
  output logic [4*NDIG-1:0]           entry_bcd,
  output logic [$clog2(NDIG+1)-1:0]   digit_count,
  output logic                        busy,
  output logic [BIN_W-1:0]            num_bin,
  output logic                        num_valid,
  output logic                        overflow,
  output logic                        key_drop
);

  localparam int unsigned CNT_W = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NDIG);

  entry_state_e      state_q, state_d;
  logic [4*NDIG-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BIN_W-1:0]  num_bin_q, num_bin_d;
  logic              num_valid_q, num_valid_d;
  logic              overflow_q, overflow_d;
  logic              key_drop_q, key_drop_d;
  logic              conv_start;
  logic              conv_done;
  logic [BIN_W-1:0]  conv_result;

  bcd_serial_to_bin #(
    .NDIG(NDIG)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (conv_start),
    .bcd_i    (entry_q),
    .done_o   (conv_done),
    .result_o (conv_result)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    count_d     = count_q;
    num_bin_d   = num_bin_q;
    num_valid_d = 1'b0;
    overflow_d  = 1'b0;
    key_drop_d  = 1'b0;
    conv_start  = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (count_q < FULL_CNT) begin
              entry_d = {entry_q[4*NDIG-5:0], key_code};
              count_d = count_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (key_code == KEY_STAR) begin
            entry_d = '0;
            count_d = '0;
          end else if (key_code == KEY_HASH && count_q != '0) begin
            conv_start = 1'b1;
            state_d    = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        key_drop_d = key_valid;
        if (conv_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        key_drop_d  = key_valid;
        num_bin_d   = conv_result;
        num_valid_d = 1'b1;
        entry_d     = '0;
        count_d     = '0;
        state_d     = ST_ENTRY;
      end
      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ENTRY;
      entry_q     <= '0;
      count_q     <= '0;
      num_bin_q   <= '0;
      num_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      key_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      num_bin_q   <= num_bin_d;
      num_valid_q <= num_valid_d;
      overflow_q  <= overflow_d;
      key_drop_q  <= key_drop_d;
    end
  end

  assign entry_bcd   = entry_q;
  assign digit_count = count_q;
  assign busy        = (state_q != ST_ENTRY);
  assign num_bin     = num_bin_q;
  assign num_valid   = num_valid_q;
  assign overflow    = overflow_q;
  assign key_drop    = key_drop_q;

endmodule
